key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce_pkg.sv | 17 +
 rtl/key_debounce_channel.sv | 100 ++++++++++
 rtl/key_debounce.sv | 56 +++++
 tb/tb_key_debounce.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared state encoding and default timing constants for the key debouncer.
package key_debounce_pkg;

  // Per-channel debounce FSM states.
  typedef enum logic [1:0] {
    StUp      = 2'd0,
    StDebDown = 2'd1,
    StDown    = 2'd2,
    StDebUp   = 2'd3
  } deb_state_e;

  // 10 MHz clock -> 10000 cycles per millisecond.
  localparam int unsigned ClkPerMsDefault   = 10000;
  // A raw level must stay stable this many ms before it is accepted.
  localparam int unsigned DebounceMsDefault = 20;

endpackage

// File: rtl/key_debounce_channel.sv
// One push-button channel: 2-flop synchronizer, debounce FSM with ms counter,
// registered level and one-cycle press/release pulses.
module debounce_channel
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = DebounceMsDefault
) (
  input  logic Clk_10M,
  input  logic Reset,
  input  logic key_raw,      // active-low, asynchronous
  input  logic tick,         // shared 1 ms strobe
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int unsigned CntW = (DEBOUNCE_MS > 0) ? $clog2(DEBOUNCE_MS + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_MS);

  logic            sync1_q, sync2_q;
  logic            key_sync;
  deb_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic            level_q, press_q, release_q;

  // Two-flop synchronizer; reset value 1 means "released".
  always_ff @(posedge Clk_10M) begin
    if (Reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  assign key_sync = ~sync2_q;

  // Debounce FSM; level and pulses are registered alongside the state.
  // Acceptance is decided on a tick once the counter already holds DEBOUNCE_MS,
  // so the partial first ms plus DEBOUNCE_MS full ms must elapse.
  always_ff @(posedge Clk_10M) begin
    if (Reset) begin
      state_q   <= StUp;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      unique case (state_q)
        StUp: begin
          if (key_sync) begin
            state_q <= StDebDown;
            cnt_q   <= '0;
          end
        end
        StDebDown: begin
          if (!key_sync) begin
            state_q <= StUp;
          end else if (tick) begin
            if (cnt_q == CntMax) begin
              state_q <= StDown;
              level_q <= 1'b1;
              press_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StDown: begin
          if (!key_sync) begin
            state_q <= StDebUp;
            cnt_q   <= '0;
          end
        end
        StDebUp: begin
          if (key_sync) begin
            state_q <= StDown;
          end else if (tick) begin
            if (cnt_q == CntMax) begin
              state_q   <= StUp;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StUp;
      endcase
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: shared 1 ms prescaler plus N_KEYS independent channels.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned N_KEYS      = 2,
  parameter int unsigned CLK_PER_MS  = ClkPerMsDefault,
  parameter int unsigned DEBOUNCE_MS = DebounceMsDefault
) (
  input  logic              Clk_10M,
  input  logic              Reset,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic              tick_1k
);

  localparam int unsigned PreW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(CLK_PER_MS - 1);

  logic [PreW-1:0] pre_q, pre_d;
  logic            tick_q;

  // Next prescaler count, wrapping at CLK_PER_MS-1.
  always_comb begin
    pre_d = (pre_q == PreMax) ? '0 : pre_q + 1'b1;
  end

  // Prescaler; tick_q is high exactly while pre_q sits at its terminal count.
  always_ff @(posedge Clk_10M) begin
    if (Reset) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= (pre_d == PreMax);
    end
  end

  assign tick_1k = tick_q;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_MS(DEBOUNCE_MS)
    ) u_chan (
      .Clk_10M    (Clk_10M),
      .Reset      (Reset),
      .key_raw    (KEY[i]),
      .tick       (tick_q),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with CLK_PER_MS = 10, DEBOUNCE_MS = 2.
module tb_key_debounce;

  logic       Clk_10M = 1'b0;
  logic       Reset   = 1'b1;
  logic [1:0] KEY     = 2'b11;
  logic [1:0] key_level, key_press, key_release;
  logic       tick_1k;

  int n_tests = 0;
  int n_fail  = 0;

  key_debounce #(
    .N_KEYS     (2),
    .CLK_PER_MS (10),
    .DEBOUNCE_MS(2)
  ) dut (
    .Clk_10M    (Clk_10M),
    .Reset      (Reset),
    .KEY        (KEY),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .tick_1k    (tick_1k)
  );

  always #5 Clk_10M = ~Clk_10M;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge Clk_10M);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    KEY   = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if ({key_level, key_press, key_release, tick_1k} !== 7'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %b want 0000000",
                 {key_level, key_press, key_release, tick_1k});
      end
    end
  endtask

  task automatic test_tick();
    logic exp;
    Reset = 1'b0;
    n_tests++;
    if ({key_level, key_press, key_release, tick_1k} !== 7'b0) begin
      n_fail++;
      $display("FAIL post_reset_cycle0: got %b want 0000000",
               {key_level, key_press, key_release, tick_1k});
    end
    for (int c = 1; c <= 40; c++) begin
      step();
      exp = ((c % 10) == 9);
      n_tests++;
      if (tick_1k !== exp) begin
        n_fail++;
        $display("FAIL tick_cycle_%0d: got %b want %b", c, tick_1k, exp);
      end
    end
  endtask

  task automatic test_clean_press();
    int lat = -1;
    int np = 0;
    int nr = 0;
    bit other_bad = 1'b0;
    bit overlap = 1'b0;
    KEY = 2'b10;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (key_press[0]) begin
        np++;
        if (lat < 0) lat = i;
      end
      if (key_release[0]) nr++;
      if (key_level[1] || key_press[1] || key_release[1]) other_bad = 1'b1;
      if ((key_press & key_release) != 2'b00) overlap = 1'b1;
    end
    n_tests++;
    if (np !== 1) begin
      n_fail++;
      $display("FAIL press_count: got %0d want 1", np);
    end
    n_tests++;
    if (lat < 23 || lat > 33) begin
      n_fail++;
      $display("FAIL press_latency: got %0d want 23..33", lat);
    end
    n_tests++;
    if (key_level[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL press_level: got %b want 1", key_level[0]);
    end
    n_tests++;
    if (nr !== 0) begin
      n_fail++;
      $display("FAIL press_no_release: got %0d want 0", nr);
    end
    n_tests++;
    if (other_bad !== 1'b0) begin
      n_fail++;
      $display("FAIL press_key1_quiet: got %b want 0", other_bad);
    end
    n_tests++;
    if (overlap !== 1'b0) begin
      n_fail++;
      $display("FAIL press_overlap: got %b want 0", overlap);
    end
  endtask

  task automatic test_release();
    int np = 0;
    int nr = 0;
    int lat = -1;
    KEY = 2'b11;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (key_press[0]) np++;
      if (key_release[0]) begin
        nr++;
        if (lat < 0) lat = i;
      end
    end
    n_tests++;
    if (nr !== 1) begin
      n_fail++;
      $display("FAIL release_count: got %0d want 1", nr);
    end
    n_tests++;
    if (lat < 23 || lat > 33) begin
      n_fail++;
      $display("FAIL release_latency: got %0d want 23..33", lat);
    end
    n_tests++;
    if (np !== 0) begin
      n_fail++;
      $display("FAIL release_no_press: got %0d want 0", np);
    end
    n_tests++;
    if (key_level[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL release_level: got %b want 0", key_level[0]);
    end
  endtask

  task automatic test_bounce();
    int np = 0;
    bit lvl_seen = 1'b0;
    for (int i = 0; i < 120; i++) begin
      KEY[0] = (i >= 60) ? 1'b1 : (((i / 7) % 2) == 0 ? 1'b0 : 1'b1);
      step();
      if (key_press[0]) np++;
      if (key_level[0]) lvl_seen = 1'b1;
    end
    n_tests++;
    if (np !== 0) begin
      n_fail++;
      $display("FAIL bounce_press: got %0d want 0", np);
    end
    n_tests++;
    if (lvl_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_level: got %b want 0", lvl_seen);
    end
  endtask

  task automatic test_simultaneous();
    int n_both = 0;
    int n_split = 0;
    KEY = 2'b00;
    for (int i = 0; i < 100; i++) begin
      step();
      if (key_press == 2'b11) n_both++;
      else if (key_press != 2'b00) n_split++;
    end
    n_tests++;
    if (n_both !== 1 || n_split !== 0) begin
      n_fail++;
      $display("FAIL simul_press: got both=%0d split=%0d want both=1 split=0", n_both, n_split);
    end
    n_tests++;
    if (key_level !== 2'b11) begin
      n_fail++;
      $display("FAIL simul_level: got %b want 11", key_level);
    end
    n_both = 0;
    n_split = 0;
    KEY = 2'b11;
    for (int i = 0; i < 100; i++) begin
      step();
      if (key_release == 2'b11) n_both++;
      else if (key_release != 2'b00) n_split++;
    end
    n_tests++;
    if (n_both !== 1 || n_split !== 0) begin
      n_fail++;
      $display("FAIL simul_release: got both=%0d split=%0d want both=1 split=0",
               n_both, n_split);
    end
    n_tests++;
    if (key_level !== 2'b00) begin
      n_fail++;
      $display("FAIL simul_release_level: got %b want 00", key_level);
    end
  endtask

  task automatic test_reset_mid();
    int lat = -1;
    int np = 0;
    KEY = 2'b10;
    repeat (5) step();  // channel 0 now debouncing the press
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if ({key_level, key_press, key_release} !== 6'b0) begin
        n_fail++;
        $display("FAIL midreset_outputs: got %b want 000000",
                 {key_level, key_press, key_release});
      end
    end
    Reset = 1'b0;
    // Sync needs 2 edges, FSM enters debounce on the 3rd; ticks are sampled at
    // edges 10, 20, 30 and the third one accepts, so the pulse shows after edge 30.
    for (int i = 1; i <= 60; i++) begin
      step();
      if (key_press[0]) begin
        np++;
        if (lat < 0) lat = i;
      end
    end
    n_tests++;
    if (lat !== 30) begin
      n_fail++;
      $display("FAIL midreset_latency: got %0d want 30", lat);
    end
    n_tests++;
    if (np !== 1) begin
      n_fail++;
      $display("FAIL midreset_press_count: got %0d want 1", np);
    end
    n_tests++;
    if (key_level[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_level: got %b want 1", key_level[0]);
    end
  endtask

  initial begin
    test_reset();
    test_tick();
    test_clean_press();
    test_release();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
